// File: rtl/store_align_split_pkg.sv
// store_align_split_pkg
// Shared definitions for the store alignment / split block:
//   - store size encoding (same encoding as the load sign-extend size field)
//   - FSM state encoding
//   - memory bus lane count
//   - size_mask(): byte mask for a right-justified store of the given size
package store_align_split_pkg;

    localparam int LANES = 8;

    localparam logic [1:0] SZ_B = 2'd0;  // 1 byte
    localparam logic [1:0] SZ_W = 2'd1;  // 2 bytes
    localparam logic [1:0] SZ_D = 2'd2;  // 4 bytes
    localparam logic [1:0] SZ_Q = 2'd3;  // 8 bytes

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    // (1 << n) - 1 with n = 1 << size.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
        logic [LANES-1:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_W:    m = 8'h03;
            SZ_D:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align_split_if.sv
// store_align_split_if
// Bundles both handshakes of the store alignment block.
//   Store side : st_valid/st_ready, st_addr, st_size, st_data
//   Memory side: mem_valid/mem_ready, mem_addr, mem_data, mem_be, mem_last
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid & ready are both 1. A producer that raises valid keeps it and its
// payload stable until that transfer; ready may depend combinationally on the
// other side but valid never depends on ready.
// Modports: slave = the alignment block, master = the store source and memory.
interface store_align_split_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_size;
    logic [63:0]       st_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_data;
    logic [7:0]        mem_be;
    logic              mem_last;

    modport slave (
        input  st_valid, st_addr, st_size, st_data, mem_ready,
        output st_ready, mem_valid, mem_addr, mem_data, mem_be, mem_last
    );

    modport master (
        output st_valid, st_addr, st_size, st_data, mem_ready,
        input  st_ready, mem_valid, mem_addr, mem_data, mem_be, mem_last
    );

endinterface

// File: rtl/store_lane_shift.sv
// store_lane_shift
// Combinational: places a right-justified store onto a 16-lane (two beat)
// window starting at byte offset i_off.
//   i_off     : st_addr[2:0]
//   i_size    : 0/1/2/3 = 1/2/4/8 bytes
//   i_data    : right-justified store data (bytes above size ignored)
//   o_be16    : byte enables over the two 8-byte lines
//   o_data128 : lane-aligned data over the two lines, disabled lanes zero
module store_lane_shift
    import store_align_split_pkg::*;
(
    input  logic [2:0]   i_off,
    input  logic [1:0]   i_size,
    input  logic [63:0]  i_data,
    output logic [15:0]  o_be16,
    output logic [127:0] o_data128
);

    logic [63:0]  w_masked;
    logic [7:0]   w_mask8;
    logic [127:0] w_d1, w_d2;
    logic [15:0]  w_b1, w_b2;

    // Size select: four-way mux clearing bytes above the store size.
    always_comb begin
        w_masked = 64'd0;
        case (i_size)
            SZ_B:    w_masked = {56'd0, i_data[7:0]};
            SZ_W:    w_masked = {48'd0, i_data[15:0]};
            SZ_D:    w_masked = {32'd0, i_data[31:0]};
            default: w_masked = i_data;
        endcase
    end

    assign w_mask8 = size_mask(i_size);

    // Log barrel shifter: 1-, 2- and 4-byte stages selected by offset bits.
    assign w_d1 = i_off[0] ? {56'd0, w_masked, 8'd0} : {64'd0, w_masked};
    assign w_d2 = i_off[1] ? {w_d1[111:0], 16'd0}    : w_d1;
    assign o_data128 = i_off[2] ? {w_d2[95:0], 32'd0} : w_d2;

    assign w_b1 = i_off[0] ? {7'd0, w_mask8, 1'b0} : {8'd0, w_mask8};
    assign w_b2 = i_off[1] ? {w_b1[13:0], 2'b00}   : w_b1;
    assign o_be16 = i_off[2] ? {w_b2[11:0], 4'b0000} : w_b2;

endmodule

// File: rtl/store_align_split.sv
// store_align_split
// Accepts one 1/2/4/8-byte store at any byte address and emits it as one or
// two 8-byte-aligned memory write beats with byte enables. A store whose bytes
// cross an 8-byte line boundary becomes two beats (low line, then next line).
// Ports:
//   CLK         : clock, rising edge
//   CLR         : synchronous active-high reset
//   bus         : store_align_split_if.slave (store and memory handshakes)
//   o_dbg_state : current FSM state (observation only)
module store_align_split
    import store_align_split_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                    CLK,
    input  logic                    CLR,
    store_align_split_if.slave      bus,
    output state_t                  o_dbg_state
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_be16;
    logic [127:0]        r_data128;
    logic                r_split;

    logic [15:0]         w_be16;
    logic [127:0]        w_data128;
    logic                w_mem_valid;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic [63:0]         w_data;
    logic [7:0]          w_be;
    logic                w_st_ready;
    logic                w_accept;
    logic                w_mem_fire;

    store_lane_shift u_lane_shift (
        .i_off     (bus.st_addr[2:0]),
        .i_size    (bus.st_size),
        .i_data    (bus.st_data),
        .o_be16    (w_be16),
        .o_data128 (w_data128)
    );

    // Beat outputs are decoded from state so IDLE drives all-zero.
    always_comb begin
        w_mem_valid = 1'b0;
        w_last      = 1'b0;
        w_addr      = '0;
        w_data      = 64'd0;
        w_be        = 8'd0;
        case (r_state)
            BEAT0: begin
                w_mem_valid = 1'b1;
                w_last      = ~r_split;
                w_addr      = r_base;
                w_data      = r_data128[63:0];
                w_be        = r_be16[7:0];
            end
            BEAT1: begin
                w_mem_valid = 1'b1;
                w_last      = 1'b1;
                w_addr      = r_base + ADDR_W'(8);  // wraps past the top line
                w_data      = r_data128[127:64];
                w_be        = r_be16[15:8];
            end
            default: ;
        endcase
    end

    assign w_mem_fire = w_mem_valid & bus.mem_ready;
    // Ready combinationally on the last-beat handshake so a new store can be
    // taken in the same cycle the previous one retires.
    assign w_st_ready = ~CLR & ((r_state == IDLE) | (w_mem_fire & w_last));
    assign w_accept   = bus.st_valid & w_st_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = BEAT0;
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (r_split)       w_next = BEAT1;
                    else if (w_accept) w_next = BEAT0;
                    else               w_next = IDLE;
                end
            end
            BEAT1: begin
                if (bus.mem_ready) w_next = w_accept ? BEAT0 : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_be16    <= 16'd0;
            r_data128 <= 128'd0;
            r_split   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_base    <= {bus.st_addr[ADDR_W-1:3], 3'b000};
                r_be16    <= w_be16;
                r_data128 <= w_data128;
                r_split   <= |w_be16[15:8];
            end
        end
    end

    assign bus.st_ready  = w_st_ready;
    assign bus.mem_valid = w_mem_valid;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_data  = w_data;
    assign bus.mem_be    = w_be;
    assign bus.mem_last  = w_last;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_store_align_split.sv
// tb_store_align_split
// Directed bench for store_align_split: reset, aligned/unaligned single beats,
// split stores (dword, qword, address wrap), back-to-back stores, backpressure
// with a pending store, and reset in the middle of a split store.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// 2 time units after it.
module tb_store_align_split;
    import store_align_split_pkg::*;

    localparam int ADDR_W = 32;
    localparam int OW     = 1 + ADDR_W + 64 + 8 + 1;

    logic   CLK = 1'b0;
    logic   CLR;
    state_t dbg_state;
    int     n_checks = 0;
    int     n_pass   = 0;

    store_align_split_if #(.ADDR_W(ADDR_W)) bus ();

    store_align_split #(.ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // Observed beat packed as {valid, addr, data, be, last}.
    function automatic logic [OW-1:0] obs();
        return {bus.mem_valid, bus.mem_addr, bus.mem_data, bus.mem_be, bus.mem_last};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [1:0] s,
                               input logic [63:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_size  = s;
        bus.st_data  = d;
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        bus.mem_ready = 1'b0;
        drive_store(32'h0000_1234, SZ_D, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        tick();
        #1;
        n_checks++;
        if (obs() !== {OW{1'b0}}) $display("FAIL reset_outputs got %h exp %h", obs(), {OW{1'b0}});
        else n_pass++;
        n_checks++;
        if (bus.st_ready !== 1'b0) $display("FAIL reset_st_ready got %b exp 0", bus.st_ready);
        else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        else n_pass++;
        bus.st_valid = 1'b0;
        tick();
        CLR = 1'b0;
        #1;
        n_checks++;
        if (bus.st_ready !== 1'b1) $display("FAIL idle_st_ready got %b exp 1", bus.st_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [OW-1:0] exp_b;
        tick();
        bus.mem_ready = 1'b1;
        drive_store(32'h0000_1003, SZ_D, 64'h0000_0000_AABB_CCDD);
        tick();
        bus.st_valid = 1'b0;
        #1;
        exp_b = {1'b1, 32'h0000_1000, 64'h00AA_BBCC_DD00_0000, 8'h78, 1'b1};
        n_checks++;
        if (obs() !== exp_b) $display("FAIL single_beat got %h exp %h", obs(), exp_b);
        else n_pass++;
        n_checks++;
        if (dbg_state !== BEAT0) $display("FAIL single_state got %0d exp %0d", dbg_state, BEAT0);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (bus.mem_valid !== 1'b0) $display("FAIL single_done got %b exp 0", bus.mem_valid);
        else n_pass++;
    endtask

    task automatic test_split();
        logic [ADDR_W-1:0] t_addr [3];
        logic [1:0]        t_size [3];
        logic [63:0]       t_data [3];
        logic [OW-1:0]     t_b0   [3];
        logic [OW-1:0]     t_b1   [3];
        t_addr[0] = 32'h0000_1006; t_size[0] = SZ_D; t_data[0] = 64'h0000_0000_1122_3344;
        t_b0[0] = {1'b1, 32'h0000_1000, 64'h3344_0000_0000_0000, 8'hC0, 1'b0};
        t_b1[0] = {1'b1, 32'h0000_1008, 64'h0000_0000_0000_1122, 8'h03, 1'b1};
        t_addr[1] = 32'h0000_2001; t_size[1] = SZ_Q; t_data[1] = 64'h0807_0605_0403_0201;
        t_b0[1] = {1'b1, 32'h0000_2000, 64'h0706_0504_0302_0100, 8'hFE, 1'b0};
        t_b1[1] = {1'b1, 32'h0000_2008, 64'h0000_0000_0000_0008, 8'h01, 1'b1};
        t_addr[2] = 32'hFFFF_FFFE; t_size[2] = SZ_D; t_data[2] = 64'h0000_0000_DEAD_BEEF;
        t_b0[2] = {1'b1, 32'hFFFF_FFF8, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b0};
        t_b1[2] = {1'b1, 32'h0000_0000, 64'h0000_0000_0000_DEAD, 8'h03, 1'b1};
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_store(t_addr[i], t_size[i], t_data[i]);
            tick();
            bus.st_valid = 1'b0;
            #1;
            n_checks++;
            if (obs() !== t_b0[i]) $display("FAIL split%0d_beat0 got %h exp %h", i, obs(), t_b0[i]);
            else n_pass++;
            n_checks++;
            if (bus.st_ready !== 1'b0) $display("FAIL split%0d_ready0 got %b exp 0", i, bus.st_ready);
            else n_pass++;
            tick();
            #1;
            n_checks++;
            if (obs() !== t_b1[i]) $display("FAIL split%0d_beat1 got %h exp %h", i, obs(), t_b1[i]);
            else n_pass++;
            tick();
            #1;
            n_checks++;
            if (bus.mem_valid !== 1'b0) $display("FAIL split%0d_done got %b exp 0", i, bus.mem_valid);
            else n_pass++;
            bus.mem_ready = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] exp_b;
        bus.mem_ready = 1'b1;
        drive_store(32'h0000_5000, SZ_B, 64'h0000_0000_0000_FF12);
        tick();
        drive_store(32'h0000_5004, SZ_W, 64'h0000_0000_1234_BEEF);
        #1;
        exp_b = {1'b1, 32'h0000_5000, 64'h0000_0000_0000_0012, 8'h01, 1'b1};
        n_checks++;
        if (obs() !== exp_b) $display("FAIL b2b_beat_a got %h exp %h", obs(), exp_b);
        else n_pass++;
        n_checks++;
        if (bus.st_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", bus.st_ready);
        else n_pass++;
        tick();
        bus.st_valid = 1'b0;
        #1;
        exp_b = {1'b1, 32'h0000_5000, 64'h0000_BEEF_0000_0000, 8'h30, 1'b1};
        n_checks++;
        if (obs() !== exp_b) $display("FAIL b2b_beat_b got %h exp %h", obs(), exp_b);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (bus.mem_valid !== 1'b0) $display("FAIL b2b_done got %b exp 0", bus.mem_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] exp_b;
        bus.mem_ready = 1'b1;
        drive_store(32'h0000_1006, SZ_D, 64'h0000_0000_5566_7788);
        tick();
        bus.st_valid = 1'b0;
        #1;
        exp_b = {1'b1, 32'h0000_1000, 64'h7788_0000_0000_0000, 8'hC0, 1'b0};
        n_checks++;
        if (obs() !== exp_b) $display("FAIL bp_beat0 got %h exp %h", obs(), exp_b);
        else n_pass++;
        tick();
        bus.mem_ready = 1'b0;
        drive_store(32'h0000_4000, SZ_Q, 64'h0123_4567_89AB_CDEF);
        exp_b = {1'b1, 32'h0000_1008, 64'h0000_0000_0000_5566, 8'h03, 1'b1};
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (obs() !== exp_b) $display("FAIL bp_hold%0d got %h exp %h", c, obs(), exp_b);
            else n_pass++;
            n_checks++;
            if (bus.st_ready !== 1'b0) $display("FAIL bp_ready%0d got %b exp 0", c, bus.st_ready);
            else n_pass++;
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.st_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", bus.st_ready);
        else n_pass++;
        tick();
        bus.st_valid = 1'b0;
        #1;
        exp_b = {1'b1, 32'h0000_4000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1};
        n_checks++;
        if (obs() !== exp_b) $display("FAIL bp_next_beat got %h exp %h", obs(), exp_b);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (bus.mem_valid !== 1'b0) $display("FAIL bp_done got %b exp 0", bus.mem_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] exp_b;
        bus.mem_ready = 1'b0;
        drive_store(32'h0000_1006, SZ_D, 64'h0000_0000_1122_3344);
        tick();
        bus.st_valid = 1'b0;
        #1;
        n_checks++;
        if (dbg_state !== BEAT0) $display("FAIL rmid_state_beat0 got %0d exp %0d", dbg_state, BEAT0);
        else n_pass++;
        CLR = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (obs() !== {OW{1'b0}}) $display("FAIL rmid_outputs got %h exp %h", obs(), {OW{1'b0}});
        else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL rmid_state got %0d exp %0d", dbg_state, IDLE);
        else n_pass++;
        n_checks++;
        if (bus.st_ready !== 1'b0) $display("FAIL rmid_ready got %b exp 0", bus.st_ready);
        else n_pass++;
        CLR = 1'b0;
        drive_store(32'h0000_3007, SZ_B, 64'h0000_0000_0000_775A);
        tick();
        bus.st_valid = 1'b0;
        #1;
        exp_b = {1'b1, 32'h0000_3000, 64'h5A00_0000_0000_0000, 8'h80, 1'b1};
        n_checks++;
        if (obs() !== exp_b) $display("FAIL rmid_byte_beat got %h exp %h", obs(), exp_b);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (bus.mem_valid !== 1'b0) $display("FAIL rmid_done got %b exp 0", bus.mem_valid);
        else n_pass++;
    endtask

    initial begin
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_size   = 2'd0;
        bus.st_data   = 64'd0;
        bus.mem_ready = 1'b0;
        CLR           = 1'b1;
        #1;
        test_reset();
        test_single();
        test_split();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
